// File: rtl/flash_controller_if.sv
// Host-side port of flash_controller: valid/ready command requests, valid-only byte responses.
interface flash_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic       req_bus;
  logic       req_chan;
  logic [2:0] req_ce;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_last;

  modport master (
    output req_valid, req_op, req_bus, req_chan, req_ce,
    input  req_ready, resp_valid, resp_data, resp_last
  );

  modport slave (
    input  req_valid, req_op, req_bus, req_chan, req_ce,
    output req_ready, resp_valid, resp_data, resp_last
  );
endinterface

// File: rtl/flash_controller.sv
// SDR ONFI NAND sequencer (RESET / READ_ID / READ_STATUS) for 2 buses x 2 channels; macro FLASH_DQ_REVERSE_EN bit-reverses DQ for packages 2-3.
// Latency: WE# falls 2 cycles after accept; req_ready only in IDLE, requests arriving while busy are dropped, responses cannot be stalled.
module flash_controller #(
  parameter int T_WP     = 2,
  parameter int T_WH     = 2,
  parameter int T_WHR    = 8,
  parameter int T_RST    = 100,
  parameter int ID_BYTES = 4
) (
  input  logic               CLK_sysClk,
  input  logic               RST_sysRst,
  flash_controller_if.slave  host,
  output logic [3:0]         B_SHARED_0_WEN_NCLK,
  output logic [3:0]         B_SHARED_1_WEN_NCLK,
  inout  wire  [7:0]         B_0_0_DQ,
  inout  wire                B_0_0_DQS,
  output logic               B_0_0_CLE,
  output logic               B_0_0_ALE,
  output logic               B_0_0_WRN,
  output logic               B_0_0_WPN,
  output logic [7:0]         B_0_0_CEN,
  inout  wire  [7:0]         B_0_1_DQ,
  inout  wire                B_0_1_DQS,
  output logic               B_0_1_CLE,
  output logic               B_0_1_ALE,
  output logic               B_0_1_WRN,
  output logic               B_0_1_WPN,
  output logic [7:0]         B_0_1_CEN,
  inout  wire  [7:0]         B_1_0_DQ,
  inout  wire                B_1_0_DQS,
  output logic               B_1_0_CLE,
  output logic               B_1_0_ALE,
  output logic               B_1_0_WRN,
  output logic               B_1_0_WPN,
  output logic [7:0]         B_1_0_CEN,
  inout  wire  [7:0]         B_1_1_DQ,
  inout  wire                B_1_1_DQS,
  output logic               B_1_1_CLE,
  output logic               B_1_1_ALE,
  output logic               B_1_1_WRN,
  output logic               B_1_1_WPN,
  output logic [7:0]         B_1_1_CEN
);

`ifdef FLASH_DQ_REVERSE_EN
  localparam bit DQ_REV_EN = 1'b1;
`else
  localparam bit DQ_REV_EN = 1'b0;
`endif

  localparam logic [1:0] OP_RESET   = 2'd0;
  localparam logic [1:0] OP_READ_ID = 2'd1;
  localparam logic [1:0] OP_NOP     = 2'd3;

  // WAIT after a read command covers only the part of tWHR not already spent in the WE# high phase (T_WHR > T_WH).
  localparam logic [15:0] WP_M1     = 16'(T_WP - 1);
  localparam logic [15:0] WH_M1     = 16'(T_WH - 1);
  localparam logic [15:0] WHR_M1    = 16'(T_WHR - T_WH - 1);
  localparam logic [15:0] RST_M1    = 16'(T_RST - 1);
  localparam logic [3:0]  LAST_BYTE = 4'(ID_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, CMD_WE, ADDR_WE, WAIT, RD_LOW, RD_HIGH, FINISH
  } state_t;

  state_t      state;
  logic [1:0]  op_r;
  logic        bus_r;
  logic        chan_r;
  logic [1:0]  pkg_r;
  logic [15:0] cnt;
  logic [3:0]  byte_cnt;
  logic        cle_r, ale_r, we_n_r, re_n_r, dq_oe_r;
  logic [7:0]  dq_r;
  logic [7:0]  cen_r;
  logic        resp_valid_r, resp_last_r;
  logic [7:0]  resp_data_r;
  logic [7:0]  dq_in;

  function automatic logic [7:0] dq_map(input logic [7:0] d, input logic rev);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7 - i];
    return rev ? r : d;
  endfunction

  function automatic logic [7:0] opcode(input logic [1:0] op);
    case (op)
      OP_RESET:   return 8'hFF;
      OP_READ_ID: return 8'h90;
      default:    return 8'h70;
    endcase
  endfunction

  wire       dq_rev    = DQ_REV_EN & pkg_r[1];
  wire       last_byte = (op_r != OP_READ_ID) || (byte_cnt == LAST_BYTE);
  wire [3:0] sel       = 4'b0001 << {bus_r, chan_r};
  wire [3:0] wen_sel   = ~({3'b000, ~we_n_r} << pkg_r);

  always_comb begin
    dq_in = B_1_1_DQ;
    case ({bus_r, chan_r})
      2'd0:    dq_in = B_0_0_DQ;
      2'd1:    dq_in = B_0_1_DQ;
      2'd2:    dq_in = B_1_0_DQ;
      default: dq_in = B_1_1_DQ;
    endcase
  end

  always_ff @(posedge CLK_sysClk) begin
    if (RST_sysRst) begin
      state        <= IDLE;
      op_r         <= OP_NOP;
      bus_r        <= 1'b0;
      chan_r       <= 1'b0;
      pkg_r        <= 2'd0;
      cnt          <= 16'd0;
      byte_cnt     <= 4'd0;
      cle_r        <= 1'b0;
      ale_r        <= 1'b0;
      we_n_r       <= 1'b1;
      re_n_r       <= 1'b1;
      dq_oe_r      <= 1'b0;
      dq_r         <= 8'h00;
      cen_r        <= 8'hFF;
      resp_valid_r <= 1'b0;
      resp_data_r  <= 8'h00;
      resp_last_r  <= 1'b0;
    end else begin
      resp_valid_r <= 1'b0;
      resp_data_r  <= 8'h00;
      resp_last_r  <= 1'b0;
      case (state)
        IDLE: if (host.req_valid) begin
          op_r   <= host.req_op;
          bus_r  <= host.req_bus;
          chan_r <= host.req_chan;
          pkg_r  <= host.req_ce[2:1];
          if (host.req_op == OP_NOP) begin
            resp_valid_r <= 1'b1;
            resp_data_r  <= 8'hFF;
            resp_last_r  <= 1'b1;
            state        <= FINISH;
          end else begin
            cen_r   <= ~(8'd1 << host.req_ce);
            cle_r   <= 1'b1;
            dq_oe_r <= 1'b1;
            dq_r    <= dq_map(opcode(host.req_op), DQ_REV_EN & host.req_ce[2]);
            state   <= SETUP;
          end
        end
        SETUP: begin
          we_n_r <= 1'b0;
          cnt    <= WP_M1;
          state  <= ale_r ? ADDR_WE : CMD_WE;
        end
        CMD_WE, ADDR_WE: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (!we_n_r) begin
            we_n_r <= 1'b1;
            cnt    <= WH_M1;
          end else if (state == CMD_WE && op_r == OP_READ_ID) begin
            // Address cycle gets its own SETUP so ALE is stable before WE# falls.
            cle_r <= 1'b0;
            ale_r <= 1'b1;
            dq_r  <= dq_map(8'h00, dq_rev);
            state <= SETUP;
          end else begin
            cle_r   <= 1'b0;
            ale_r   <= 1'b0;
            dq_oe_r <= 1'b0;
            cnt     <= (op_r == OP_RESET) ? RST_M1 : WHR_M1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (op_r == OP_RESET) begin
            resp_valid_r <= 1'b1;
            resp_last_r  <= 1'b1;
            state        <= FINISH;
          end else begin
            re_n_r   <= 1'b0;
            cnt      <= WP_M1;
            byte_cnt <= 4'd0;
            state    <= RD_LOW;
          end
        end
        RD_LOW: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else begin
            re_n_r       <= 1'b1;
            resp_valid_r <= 1'b1;
            resp_data_r  <= dq_map(dq_in, dq_rev);
            resp_last_r  <= last_byte;
            cnt          <= WH_M1;
            state        <= RD_HIGH;
          end
        end
        RD_HIGH: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (last_byte) begin
            state <= FINISH;
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
            re_n_r   <= 1'b0;
            cnt      <= WP_M1;
            state    <= RD_LOW;
          end
        end
        FINISH: begin
          cen_r   <= 8'hFF;
          dq_oe_r <= 1'b0;
          cle_r   <= 1'b0;
          ale_r   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign host.req_ready  = (state == IDLE);
  assign host.resp_valid = resp_valid_r;
  assign host.resp_data  = resp_data_r;
  assign host.resp_last  = resp_last_r;

  assign B_SHARED_0_WEN_NCLK = bus_r ? 4'hF : wen_sel;
  assign B_SHARED_1_WEN_NCLK = bus_r ? wen_sel : 4'hF;

  assign B_0_0_DQ  = (dq_oe_r && sel[0]) ? dq_r : 8'bz;
  assign B_0_1_DQ  = (dq_oe_r && sel[1]) ? dq_r : 8'bz;
  assign B_1_0_DQ  = (dq_oe_r && sel[2]) ? dq_r : 8'bz;
  assign B_1_1_DQ  = (dq_oe_r && sel[3]) ? dq_r : 8'bz;
  assign B_0_0_DQS = 1'bz;
  assign B_0_1_DQS = 1'bz;
  assign B_1_0_DQS = 1'bz;
  assign B_1_1_DQS = 1'bz;

  assign B_0_0_CLE = cle_r & sel[0];
  assign B_0_1_CLE = cle_r & sel[1];
  assign B_1_0_CLE = cle_r & sel[2];
  assign B_1_1_CLE = cle_r & sel[3];
  assign B_0_0_ALE = ale_r & sel[0];
  assign B_0_1_ALE = ale_r & sel[1];
  assign B_1_0_ALE = ale_r & sel[2];
  assign B_1_1_ALE = ale_r & sel[3];
  assign B_0_0_WRN = re_n_r | ~sel[0];
  assign B_0_1_WRN = re_n_r | ~sel[1];
  assign B_1_0_WRN = re_n_r | ~sel[2];
  assign B_1_1_WRN = re_n_r | ~sel[3];
  assign B_0_0_WPN = 1'b1;
  assign B_0_1_WPN = 1'b1;
  assign B_1_0_WPN = 1'b1;
  assign B_1_1_WPN = 1'b1;
  assign B_0_0_CEN = sel[0] ? cen_r : 8'hFF;
  assign B_0_1_CEN = sel[1] ? cen_r : 8'hFF;
  assign B_1_0_CEN = sel[2] ? cen_r : 8'hFF;
  assign B_1_1_CEN = sel[3] ? cen_r : 8'hFF;

endmodule

// File: tb/tb_flash_controller.sv
// Directed bench for flash_controller with a small NAND/board model driving DQ while RE# is low.
`timescale 1ns/1ps
module tb_flash_controller;
  localparam int T_WP = 2, T_WH = 2, T_WHR = 8, T_RST = 100, ID_BYTES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flash_controller_if host_if();

  wire [3:0]      wen0, wen1;
  wire [7:0]      dq00, dq01, dq10, dq11;
  wire            dqs00, dqs01, dqs10, dqs11;
  wire [3:0]      cle, ale, wrn, wpn;
  wire [3:0][7:0] cen;

  flash_controller #(.T_WP(T_WP), .T_WH(T_WH), .T_WHR(T_WHR), .T_RST(T_RST), .ID_BYTES(ID_BYTES)) dut (
    .CLK_sysClk(clk), .RST_sysRst(rst), .host(host_if),
    .B_SHARED_0_WEN_NCLK(wen0), .B_SHARED_1_WEN_NCLK(wen1),
    .B_0_0_DQ(dq00), .B_0_0_DQS(dqs00), .B_0_0_CLE(cle[0]), .B_0_0_ALE(ale[0]),
    .B_0_0_WRN(wrn[0]), .B_0_0_WPN(wpn[0]), .B_0_0_CEN(cen[0]),
    .B_0_1_DQ(dq01), .B_0_1_DQS(dqs01), .B_0_1_CLE(cle[1]), .B_0_1_ALE(ale[1]),
    .B_0_1_WRN(wrn[1]), .B_0_1_WPN(wpn[1]), .B_0_1_CEN(cen[1]),
    .B_1_0_DQ(dq10), .B_1_0_DQS(dqs10), .B_1_0_CLE(cle[2]), .B_1_0_ALE(ale[2]),
    .B_1_0_WRN(wrn[2]), .B_1_0_WPN(wpn[2]), .B_1_0_CEN(cen[2]),
    .B_1_1_DQ(dq11), .B_1_1_DQS(dqs11), .B_1_1_CLE(cle[3]), .B_1_1_ALE(ale[3]),
    .B_1_1_WRN(wrn[3]), .B_1_1_WPN(wpn[3]), .B_1_1_CEN(cen[3])
  );

  // NAND + board model: ID sequence or status byte, bit-reversed on the board for reversed packages.
  logic [7:0] id_tab [4] = '{8'h2C, 8'hDC, 8'h90, 8'h95};
  logic       model_id  = 1'b0;
  logic       model_rev = 1'b0;
  logic [2:0] rd_idx    = 3'd0;
  logic       re_prev   = 1'b1;
  wire        re_any_n  = &wrn;
  wire [7:0]  nand_byte  = model_id ? id_tab[rd_idx[1:0]] : 8'hE0;
  wire [7:0]  board_byte = model_rev ? {nand_byte[0], nand_byte[1], nand_byte[2], nand_byte[3],
                                        nand_byte[4], nand_byte[5], nand_byte[6], nand_byte[7]} : nand_byte;

  always @(posedge clk) begin
    re_prev <= re_any_n;
    if (|cle) rd_idx <= 3'd0;
    else if (re_any_n && !re_prev) rd_idx <= rd_idx + 3'd1;
  end

  assign dq00 = wrn[0] ? 8'bz : board_byte;
  assign dq01 = wrn[1] ? 8'bz : board_byte;
  assign dq10 = wrn[2] ? 8'bz : board_byte;
  assign dq11 = wrn[3] ? 8'bz : board_byte;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_dq(input int i);
    case (i)
      0: return dq00;
      1: return dq01;
      2: return dq10;
      default: return dq11;
    endcase
  endfunction

  int         cyc_done, we_low, we_first, cmd_we, addr_we, re_low, re_first, nresp, resp_first;
  logic [7:0] cmd_dq, addr_dq, cen_seen, last_mask;
  logic [7:0] resp_b [8];
  logic       touched;

  task automatic run_cmd(input logic [1:0] op, input logic b, input logic c, input logic [2:0] ce);
    int sel, pkg;
    logic [3:0] wv, wo;
    sel = int'(b) * 2 + int'(c);
    pkg = int'(ce[2:1]);
    cyc_done = 0; we_low = 0; we_first = 0; cmd_we = 0; addr_we = 0; re_low = 0; re_first = 0;
    nresp = 0; resp_first = 0; cmd_dq = 8'h00; addr_dq = 8'h00; cen_seen = 8'hFF; last_mask = 8'h00;
    touched = 1'b0;
    for (int i = 0; i < 8; i++) resp_b[i] = 8'h00;
    @(negedge clk);
    host_if.req_valid = 1'b1; host_if.req_op = op;
    host_if.req_bus = b; host_if.req_chan = c; host_if.req_ce = ce;
    @(negedge clk);
    host_if.req_valid = 1'b0;
    for (int cyc = 1; cyc < 400 && cyc_done == 0; cyc++) begin
      if (cyc > 1) @(negedge clk);
      wv = b ? wen1 : wen0;
      wo = b ? wen0 : wen1;
      if (!wv[pkg]) begin
        we_low++;
        if (we_first == 0) we_first = cyc;
        if (cle[sel]) begin cmd_we++; cmd_dq = get_dq(sel); end
        if (ale[sel]) begin addr_we++; addr_dq = get_dq(sel); end
      end
      if (!wrn[sel]) begin
        re_low++;
        if (re_first == 0) re_first = cyc;
      end
      if (cen[sel] != 8'hFF) cen_seen = cen[sel];
      if (host_if.resp_valid) begin
        if (nresp == 0) resp_first = cyc;
        if (nresp < 8) begin
          resp_b[nresp] = host_if.resp_data;
          last_mask[nresp] = host_if.resp_last;
        end
        nresp++;
      end
      if (wo != 4'hF || (wv | (4'b0001 << pkg)) != 4'hF) touched = 1'b1;
      for (int j = 0; j < 4; j++)
        if (j != sel && (cen[j] != 8'hFF || cle[j] || ale[j] || !wrn[j])) touched = 1'b1;
      if (host_if.req_ready) cyc_done = cyc;
    end
    chk("cmd_completes_in_budget", int'(cyc_done != 0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic saw_resp;
    host_if.req_valid = 1'b0; host_if.req_op = 2'd3;
    host_if.req_bus = 1'b0; host_if.req_chan = 1'b0; host_if.req_ce = 3'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("rst_cen%0d", i), int'(cen[i]), 8'hFF);
    chk("rst_wen0", int'(wen0), 4'hF);
    chk("rst_wen1", int'(wen1), 4'hF);
    chk("rst_wrn", int'(wrn), 4'hF);
    chk("rst_wpn", int'(wpn), 4'hF);
    chk("rst_cle_ale", int'({cle, ale}), 0);
    chk("rst_req_ready", int'(host_if.req_ready), 1);
    chk("rst_resp", int'({host_if.resp_valid, host_if.resp_data, host_if.resp_last}), 0);

    // READ_STATUS bus0/chan0/ce0
    model_id = 1'b0; model_rev = 1'b0;
    run_cmd(2'd2, 1'b0, 1'b0, 3'd0);
    chk("rs_we_first", we_first, 2);
    chk("rs_we_low", we_low, T_WP);
    chk("rs_cle_we", cmd_we, T_WP);
    chk("rs_cmd_dq", int'(cmd_dq), 8'h70);
    chk("rs_no_addr", addr_we, 0);
    chk("rs_cen", int'(cen_seen), 8'hFE);
    chk("rs_re_first", re_first, 2 + T_WP + T_WHR);
    chk("rs_re_low", re_low, T_WP);
    chk("rs_nresp", nresp, 1);
    chk("rs_data", int'(resp_b[0]), 8'hE0);
    chk("rs_last", int'(last_mask), 8'h01);
    chk("rs_resp_cycle", resp_first, 2 + 2 * T_WP + T_WHR);
    chk("rs_ready_cycle", cyc_done, 2 + 2 * T_WP + T_WHR + T_WH + 1);
    chk("rs_other_pins", int'(touched), 0);

    // READ_ID bus1/chan1/ce2
    model_id = 1'b1; model_rev = 1'b0;
    run_cmd(2'd1, 1'b1, 1'b1, 3'd2);
    chk("id_cmd_dq", int'(cmd_dq), 8'h90);
    chk("id_ale_we", addr_we, T_WP);
    chk("id_addr_dq", int'(addr_dq), 8'h00);
    chk("id_cen", int'(cen_seen), 8'hFB);
    chk("id_nresp", nresp, ID_BYTES);
    chk("id_b0", int'(resp_b[0]), 8'h2C);
    chk("id_b1", int'(resp_b[1]), 8'hDC);
    chk("id_b2", int'(resp_b[2]), 8'h90);
    chk("id_b3", int'(resp_b[3]), 8'h95);
    chk("id_last_mask", int'(last_mask), 8'h08);
    chk("id_other_pins", int'(touched), 0);

    // READ_ID bus0/chan0/ce4: package 2 is bit-reversed on the board
    model_id = 1'b1; model_rev = 1'b1;
    run_cmd(2'd1, 1'b0, 1'b0, 3'd4);
    model_rev = 1'b0;
`ifdef FLASH_DQ_REVERSE_EN
    chk("rev_cmd_dq", int'(cmd_dq), 8'h09);
    chk("rev_b0", int'(resp_b[0]), 8'h2C);
`else
    chk("rev_cmd_dq", int'(cmd_dq), 8'h90);
    chk("rev_b0", int'(resp_b[0]), 8'h34);
`endif
    chk("rev_nresp", nresp, ID_BYTES);
    chk("rev_cen", int'(cen_seen), 8'hEF);

    // RESET then READ_STATUS on bus0/chan1/ce1
    model_id = 1'b0;
    run_cmd(2'd0, 1'b0, 1'b1, 3'd1);
    chk("rst_cmd_dq", int'(cmd_dq), 8'hFF);
    chk("rst_nresp", nresp, 1);
    chk("rst_data", int'(resp_b[0]), 8'h00);
    chk("rst_last", int'(last_mask), 8'h01);
    chk("rst_wait_ge_trst", int'(resp_first >= T_RST), 1);
    chk("rst_no_read", re_low, 0);
    run_cmd(2'd2, 1'b0, 1'b1, 3'd1);
    chk("rst_status", int'(resp_b[0]), 8'hE0);

    // NOP: no pin activity, single 0xFF one cycle after accept
    run_cmd(2'd3, 1'b1, 1'b0, 3'd7);
    chk("nop_nresp", nresp, 1);
    chk("nop_data", int'(resp_b[0]), 8'hFF);
    chk("nop_last", int'(last_mask), 8'h01);
    chk("nop_resp_cycle", resp_first, 1);
    chk("nop_no_we", we_low, 0);
    chk("nop_no_cen", int'(cen_seen), 8'hFF);

    // Reset asserted during the WHR wait of a READ_STATUS
    @(negedge clk);
    host_if.req_valid = 1'b1; host_if.req_op = 2'd2;
    host_if.req_bus = 1'b0; host_if.req_chan = 1'b0; host_if.req_ce = 3'd0;
    @(negedge clk);
    host_if.req_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_cen_active", int'(cen[0]), 8'hFE);
    chk("mid_in_wait", int'({wen0, wrn[0]}), 5'h1F);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_cen_idle", int'(cen[0]), 8'hFF);
    chk("mid_wen_idle", int'(wen0), 4'hF);
    chk("mid_pins_idle", int'({cle, ale, wrn}), 12'h00F);
    chk("mid_resp_quiet", int'(host_if.resp_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    saw_resp = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (host_if.resp_valid) saw_resp = 1'b1;
    end
    chk("mid_no_resp", int'(saw_resp), 0);
    chk("mid_ready", int'(host_if.req_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
